// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encodings and widths for the unified memory port arbiter.
package mem_arb_pkg;
    localparam int ADDR_W = 32;
    typedef enum logic [1:0] {
        ARB_IDLE      = 2'd0,
        ARB_SERVE_IF  = 2'd1,
        ARB_SERVE_MEM = 2'd2
    } arb_state_t;
endpackage

// File: rtl/starve_counter.sv
// starve_counter: saturating count of MEM grants taken while a fetch was waiting.
module starve_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    input  logic [W-1:0] limit,
    output logic         at_limit
);
    logic [W-1:0] cnt;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (inc && cnt != limit) cnt <= cnt + 1'b1;
    end
    assign at_limit = cnt == limit;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one RAM port between instruction fetch and data memory,
// MEM first, with a starvation bound that eventually forces a fetch grant.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_done,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic [31:0]       mem_rdata,
    output logic              mem_done,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    input  logic              ram_ready
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    arb_state_t state;
    logic if_ok, mem_ok, grant_if, grant_mem, at_limit, idle;
    // a requester whose done is showing still holds req for the finished access
    assign if_ok     = if_req & ~if_done;
    assign mem_ok    = mem_req & ~mem_done;
    assign idle      = state == ARB_IDLE;
    assign grant_if  = idle & if_ok & (~mem_ok | at_limit);
    assign grant_mem = idle & mem_ok & ~grant_if;
    assign stall_if  = if_req & ~if_done;
    assign stall_mem = mem_req & ~mem_done;
    starve_counter #(.W(CW)) u_starve (
        .clk      (clk),
        .reset    (reset),
        .inc      (grant_mem & if_req),
        .clr      (grant_if | (idle & ~if_req)),
        .limit    (CW'(STARVE_LIMIT)),
        .at_limit (at_limit)
    );
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ARB_IDLE;
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            if_done   <= 1'b0;
            mem_done  <= 1'b0;
            if_rdata  <= '0;
            mem_rdata <= '0;
        end else begin
            if_done  <= 1'b0;
            mem_done <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (grant_if) begin
                        state     <= ARB_SERVE_IF;
                        ram_en    <= 1'b1;
                        ram_we    <= 1'b0;
                        ram_addr  <= if_addr;
                        ram_wdata <= '0;
                    end else if (grant_mem) begin
                        state     <= ARB_SERVE_MEM;
                        ram_en    <= 1'b1;
                        ram_we    <= mem_we;
                        ram_addr  <= mem_addr;
                        ram_wdata <= mem_wdata;
                    end
                end
                ARB_SERVE_IF: if (ram_ready) begin
                    state    <= ARB_IDLE;
                    ram_en   <= 1'b0;
                    ram_we   <= 1'b0;
                    if_done  <= 1'b1;
                    if_rdata <= ram_rdata;
                end
                ARB_SERVE_MEM: if (ram_ready) begin
                    state    <= ARB_IDLE;
                    ram_en   <= 1'b0;
                    ram_we   <= 1'b0;
                    mem_done <= 1'b1;
                    if (!ram_we) mem_rdata <= ram_rdata;
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end
endmodule
